// File: rtl/shake_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shake_ctrl
//  Purpose  : Sequencing controller for the SHAKE core. It accepts a hash
//             command, drives the shared size_counter through message
//             absorption, padding and squeezing, and issues permutation
//             start requests to the Keccak datapath.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    W          : lane/word width in bits (64)
//    WIDTH      : length/counter width, matches the size_counter instance
//    RATE_WORDS : rate in words (21 = SHAKE128, 17 = SHAKE256)
//  Ports
//    clk, rst                    : clock; asynchronous active-low reset
//    cmd_valid/cmd_ready         : command handshake, in_len/out_len in bits
//    din_valid/din_ready/din_bits: message word handshake and valid bit count
//    cnt_*                       : size_counter load/step/enable and flags
//    word_idx                    : rate word index for absorb, pad, squeeze
//    pad_en/pad_offset           : one-cycle pad strobe and bit offset
//    perm_start/perm_done        : permutation request / completion pulse
//    dout_valid/dout_ready/
//    dout_last/dout_bits         : output word handshake and qualifiers
//    busy                        : high whenever the FSM is not idle
//  Build option
//    SHAKE_CTRL_ABORT_EN : adds the 'abort' input. A non-idle command is
//                          dropped on the next edge; permutation states
//                          first wait for perm_done.
// ============================================================================
module shake_ctrl #(
    parameter int W          = 64,
    parameter int WIDTH      = 32,
    parameter int RATE_WORDS = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] in_len,
    input  logic [WIDTH-1:0] out_len,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [6:0]       din_bits,
    output logic [WIDTH-1:0] cnt_data_in,
    output logic [WIDTH-1:0] cnt_step,
    output logic [10:0]      cnt_block_size,
    output logic             cnt_en_data,
    output logic             cnt_en_count,
    output logic             cnt_en_block,
    input  logic [WIDTH-1:0] cnt_value,
    input  logic             cnt_last_word,
    input  logic             cnt_end,
    output logic [4:0]       word_idx,
    output logic             pad_en,
    output logic [6:0]       pad_offset,
    output logic             perm_start,
    input  logic             perm_done,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic [6:0]       dout_bits,
`ifdef SHAKE_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy
);

    // ------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------
    localparam logic [WIDTH-1:0] c_w_cnt    = WIDTH'(W);
    localparam logic [6:0]       c_w_bits   = 7'(W);
    localparam logic [4:0]       c_last_idx = 5'(RATE_WORDS - 1);
    localparam logic [10:0]      c_block    = 11'(RATE_WORDS * W);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_IN  = 4'd1;
    localparam logic [3:0] S_ABSORB   = 4'd2;
    localparam logic [3:0] S_PERM_ABS = 4'd3;
    localparam logic [3:0] S_PAD      = 4'd4;
    localparam logic [3:0] S_PERM_PAD = 4'd5;
    localparam logic [3:0] S_LOAD_OUT = 4'd6;
    localparam logic [3:0] S_SQUEEZE  = 4'd7;
    localparam logic [3:0] S_PERM_SQZ = 4'd8;

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [WIDTH-1:0] r_out_len;
    logic [4:0]       r_word_idx;
    logic [6:0]       r_pad_offset;
    logic             r_perm_issued;   // start already sent in this PERM_* visit
    logic             r_settle;        // second (settle) cycle of LOAD_OUT

    logic [6:0]       w_cnt_bits;
    logic             w_is_perm;
    logic             w_perm_done_ok;
    logic             w_cmd_acc;
    logic             w_din_hs;
    logic             w_dout_hs;
    logic             w_full_word;
    logic             w_idx_wrap;

    // ------------------------------------------------------------------
    // Shared combinational helpers
    // ------------------------------------------------------------------
    // Both the absorb and squeeze word sizes are min(counter, W).
    assign w_cnt_bits = (cnt_value >= c_w_cnt) ? c_w_bits : cnt_value[6:0];

    assign w_is_perm  = (r_state == S_PERM_ABS) || (r_state == S_PERM_PAD) ||
                        (r_state == S_PERM_SQZ);

    // A done pulse is only honoured after our own start has gone out, so a
    // stray pulse coinciding with the entry cycle cannot end the wait.
    assign w_perm_done_ok = w_is_perm && r_perm_issued && perm_done;

    // Handshakes are formed from state and registered counter flags only.
    assign w_cmd_acc   = (r_state == S_IDLE) && cmd_valid;
    assign w_din_hs    = (r_state == S_ABSORB) && !cnt_end && din_valid;
    assign w_dout_hs   = (r_state == S_SQUEEZE) && dout_ready;
    assign w_full_word = (w_cnt_bits == c_w_bits);
    assign w_idx_wrap  = (r_word_idx == c_last_idx);

`ifdef SHAKE_CTRL_ABORT_EN
    logic r_abort_pend;                // abort seen while a permutation runs
    logic w_abort_req;
    assign w_abort_req = abort || r_abort_pend;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next_state = S_LOAD_IN;
            end
            S_LOAD_IN: begin
                w_next_state = S_ABSORB;
            end
            S_ABSORB: begin
                if (cnt_end) begin
                    w_next_state = S_PAD;
                end else if (w_din_hs && w_full_word && w_idx_wrap) begin
                    w_next_state = S_PERM_ABS;
                end
            end
            S_PERM_ABS: begin
                if (w_perm_done_ok) w_next_state = S_LOAD_IN;
            end
            S_PAD: begin
                w_next_state = S_PERM_PAD;
            end
            S_PERM_PAD: begin
                if (w_perm_done_ok) w_next_state = S_LOAD_OUT;
            end
            S_LOAD_OUT: begin
                if (r_settle) begin
                    w_next_state = (r_out_len == '0) ? S_IDLE : S_SQUEEZE;
                end
            end
            S_SQUEEZE: begin
                if (w_dout_hs) begin
                    if (cnt_last_word) begin
                        w_next_state = S_IDLE;
                    end else if (w_idx_wrap) begin
                        w_next_state = S_PERM_SQZ;
                    end
                end
            end
            S_PERM_SQZ: begin
                if (w_perm_done_ok) w_next_state = S_SQUEEZE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
`ifdef SHAKE_CTRL_ABORT_EN
        // Abort overrides everything, but a running permutation is allowed
        // to finish so the datapath is never left mid-round.
        if ((r_state != S_IDLE) && w_abort_req) begin
            if (!w_is_perm || w_perm_done_ok) begin
                w_next_state = S_IDLE;
            end else begin
                w_next_state = r_state;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready    = 1'b0;
        din_ready    = 1'b0;
        dout_valid   = 1'b0;
        dout_last    = 1'b0;
        pad_en       = 1'b0;
        perm_start   = 1'b0;
        cnt_en_data  = 1'b0;
        cnt_en_count = 1'b0;
        cnt_en_block = 1'b0;
        cnt_data_in  = in_len;
        case (r_state)
            S_IDLE: begin
                cmd_ready    = 1'b1;
                cnt_en_data  = w_cmd_acc;
                cnt_en_block = w_cmd_acc;
            end
            S_ABSORB: begin
                din_ready    = !cnt_end;
                cnt_en_count = w_din_hs;
            end
            S_PAD: begin
                pad_en = 1'b1;
            end
            S_PERM_ABS, S_PERM_PAD, S_PERM_SQZ: begin
                perm_start = !r_perm_issued;
            end
            S_LOAD_OUT: begin
                cnt_data_in = r_out_len;
                cnt_en_data = !r_settle;
            end
            S_SQUEEZE: begin
                dout_valid   = 1'b1;
                dout_last    = cnt_last_word;
                cnt_en_count = w_dout_hs;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign busy           = (r_state != S_IDLE);
    assign din_bits       = w_cnt_bits;
    assign dout_bits      = w_cnt_bits;
    assign word_idx       = r_word_idx;
    assign pad_offset     = r_pad_offset;
    assign cnt_step       = c_w_cnt;
    assign cnt_block_size = c_block;

    // ------------------------------------------------------------------
    // FSM-qualifying flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perm_issued <= 1'b0;
            r_settle      <= 1'b0;
        end else begin
            r_perm_issued <= w_is_perm && (w_next_state == r_state);
            r_settle      <= (r_state == S_LOAD_OUT) && (w_next_state == S_LOAD_OUT);
        end
    end

`ifdef SHAKE_CTRL_ABORT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_abort_pend <= 1'b0;
        end else if (w_next_state == S_IDLE) begin
            r_abort_pend <= 1'b0;
        end else if (abort && w_is_perm) begin
            r_abort_pend <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Command registers, rate word index and pad offset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_len    <= '0;
            r_word_idx   <= '0;
            r_pad_offset <= '0;
        end else begin
            if (w_cmd_acc) begin
                r_out_len    <= out_len;
                r_word_idx   <= '0;
                // A zero-length message must pad at bit 0, not at a stale offset.
                r_pad_offset <= '0;
            end

            if (w_din_hs) begin
                if (w_full_word) begin
                    r_pad_offset <= '0;
                    r_word_idx   <= w_idx_wrap ? 5'd0 : r_word_idx + 5'd1;
                end else begin
                    // Partial word: the pad lands right after it in the same lane.
                    r_pad_offset <= w_cnt_bits;
                end
            end

            if ((r_state == S_PERM_PAD) && w_perm_done_ok) begin
                r_word_idx <= '0;
            end

            if (w_dout_hs) begin
                r_word_idx <= w_idx_wrap ? 5'd0 : r_word_idx + 5'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shake_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shake_ctrl
//  Purpose  : Self-checking bench for shake_ctrl. A behavioural size_counter
//             and permutation responder surround the DUT; expected events
//             are queued at command issue and popped by an independent
//             monitor as the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shake_ctrl;

    localparam int W     = 64;
    localparam int WIDTH = 32;
    localparam int RW    = 21;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] in_len = '0;
    logic [WIDTH-1:0] out_len = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic [6:0]       din_bits;
    logic [WIDTH-1:0] cnt_data_in;
    logic [WIDTH-1:0] cnt_step;
    logic [10:0]      cnt_block_size;
    logic             cnt_en_data;
    logic             cnt_en_count;
    logic             cnt_en_block;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_last_word;
    logic             cnt_end;
    logic [4:0]       word_idx;
    logic             pad_en;
    logic [6:0]       pad_offset;
    logic             perm_start;
    logic             perm_done;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             dout_last;
    logic [6:0]       dout_bits;
    logic             busy;
    logic             abort = 1'b0;

    always #5 clk = ~clk;

    shake_ctrl #(.W(W), .WIDTH(WIDTH), .RATE_WORDS(RW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .in_len(in_len), .out_len(out_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_bits(din_bits),
        .cnt_data_in(cnt_data_in), .cnt_step(cnt_step), .cnt_block_size(cnt_block_size),
        .cnt_en_data(cnt_en_data), .cnt_en_count(cnt_en_count), .cnt_en_block(cnt_en_block),
        .cnt_value(cnt_value), .cnt_last_word(cnt_last_word), .cnt_end(cnt_end),
        .word_idx(word_idx), .pad_en(pad_en), .pad_offset(pad_offset),
        .perm_start(perm_start), .perm_done(perm_done),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .dout_bits(dout_bits),
`ifdef SHAKE_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy)
    );

    // ---------------- behavioural size_counter ----------------
    logic [WIDTH-1:0] cnt_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else if (cnt_en_data) cnt_q <= cnt_data_in;
        else if (cnt_en_count) cnt_q <= (cnt_q > WIDTH'(W)) ? cnt_q - WIDTH'(W) : '0;
    end
    assign cnt_value     = cnt_q;
    assign cnt_end       = (cnt_q == '0);
    assign cnt_last_word = (cnt_q != '0) && (cnt_q <= WIDTH'(W));

    // ---------------- permutation responder (done 3 cycles after start) ----
    int pd_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pd_cnt    <= 0;
            perm_done <= 1'b0;
        end else begin
            perm_done <= 1'b0;
            if (perm_start) pd_cnt <= 3;
            else if (pd_cnt != 0) begin
                pd_cnt    <= pd_cnt - 1;
                perm_done <= (pd_cnt == 1);
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] idx;
        logic [6:0] bits;
        logic       last;
    } ev_t;
    localparam logic [1:0] K_DIN = 2'd0, K_PAD = 2'd1, K_PERM = 2'd2, K_DOUT = 2'd3;

    ev_t exp_q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  n_perm = 0, n_dout = 0, n_perm_first = -1;
    bit  chk_en = 1'b1;
    bit  bp = 1'b0;

    function automatic ev_t mk(logic [1:0] k, int i, int b, logic l);
        ev_t e;
        e.kind = k; e.idx = 5'(i); e.bits = 7'(b); e.last = l;
        return e;
    endfunction

    // Reference sequence derived from the command lengths alone.
    task automatic push_expected(input int il, input int ol);
        int rem, idx, off, b;
        rem = il; idx = 0; off = 0;
        while (rem > 0) begin
            b = (rem > W) ? W : rem;
            exp_q.push_back(mk(K_DIN, idx, b, 1'b0));
            rem -= b;
            if (b == W) begin
                off = 0;
                if (idx == RW - 1) begin
                    idx = 0;
                    exp_q.push_back(mk(K_PERM, 0, 0, 1'b0));
                end else idx++;
            end else off = b;
        end
        exp_q.push_back(mk(K_PAD, idx, off, 1'b0));
        exp_q.push_back(mk(K_PERM, 0, 0, 1'b0));
        rem = ol; idx = 0;
        while (rem > 0) begin
            b = (rem > W) ? W : rem;
            exp_q.push_back(mk(K_DOUT, idx, b, rem <= W));
            if (rem > W) begin
                if (idx == RW - 1) begin
                    idx = 0;
                    exp_q.push_back(mk(K_PERM, 0, 0, 1'b0));
                end else idx++;
            end
            rem -= b;
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst && chk_en) begin
            ev_t act, e;
            bit  hit;
            hit = 1'b0;
            act = '0;
            compared++;
            if (cnt_en_data && cnt_en_count) begin
                mismatched++;
                $display("FAIL en_exclusive: en_data=1 en_count=1, required not both");
            end
            if (din_valid && din_ready) begin
                act = mk(K_DIN, int'(word_idx), int'(din_bits), 1'b0); hit = 1'b1;
            end else if (pad_en) begin
                act = mk(K_PAD, int'(word_idx), int'(pad_offset), 1'b0); hit = 1'b1;
            end else if (perm_start) begin
                act = mk(K_PERM, 0, 0, 1'b0); hit = 1'b1; n_perm++;
            end else if (dout_valid && dout_ready) begin
                act = mk(K_DOUT, int'(word_idx), int'(dout_bits), dout_last); hit = 1'b1;
                if (n_dout == 0) n_perm_first = n_perm;
                n_dout++;
            end
            if (hit) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL event: got kind=%0d idx=%0d bits=%0d last=%0d, required no event",
                             act.kind, act.idx, act.bits, act.last);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        mismatched++;
                        $display("FAIL event: got kind=%0d idx=%0d bits=%0d last=%0d, required kind=%0d idx=%0d bits=%0d last=%0d",
                                 act.kind, act.idx, act.bits, act.last, e.kind, e.idx, e.bits, e.last);
                    end
                end
            end
        end
    end

    // ---------------- input handshake drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp) begin
                din_valid  = 1'($urandom_range(0, 1));
                dout_ready = 1'($urandom_range(0, 1));
            end else begin
                din_valid  = 1'b1;
                dout_ready = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic issue(input int il, input int ol);
        @(negedge clk);
        check("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        in_len    = WIDTH'(il);
        out_len   = WIDTH'(ol);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic clear_counts();
        n_perm = 0; n_dout = 0; n_perm_first = -1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run(input string name, input int il, input int ol);
        clear_counts();
        push_expected(il, ol);
        issue(il, ol);
        wait_idle(name);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({cmd_ready, busy, din_ready, dout_valid, pad_en, perm_start,
                   cnt_en_data, cnt_en_count, cnt_en_block, word_idx, pad_offset}),
              64'({1'b1, 8'b0, 5'd0, 7'd0}));
        check("cnt_step", 64'(cnt_step), 64'd64);
        check("cnt_block_size", 64'(cnt_block_size), 64'd1344);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Empty message, 256-bit output: 4 full words, last on the 4th.
        run("len0_out256", 0, 256);
        check("len0_dout_count", 64'(n_dout), 64'd4);
        check("len0_perm_count", 64'(n_perm), 64'd1);

        // 100-bit message: full word, then 36 bits, pad at idx 1 offset 36.
        clear_counts();
        push_expected(100, 128);
        issue(100, 128);
        @(negedge clk);
        check("load_in_din_ready", 64'({busy, din_ready}), 64'({1'b1, 1'b0}));
        @(negedge clk);
        check("absorb_din_ready", 64'({din_ready, din_bits}), 64'({1'b1, 7'd64}));
        wait_idle("len100");
        check("len100_dout_count", 64'(n_dout), 64'd2);

        // Exactly one rate block in, 1400 bits out.
        run("len1344_out1400", 1344, 1400);
        check("len1344_perm_before_dout", 64'(n_perm_first), 64'd2);
        check("len1344_dout_count", 64'(n_dout), 64'd22);
        check("len1344_perm_count", 64'(n_perm), 64'd3);

        // Backpressure on both streams; same event sequence as full rate.
        bp = 1'b1;
        run("bp_len1500_out1400", 1500, 1400);
        check("bp_dout_count", 64'(n_dout), 64'd22);
        bp = 1'b0;

        // Zero-length output returns to idle straight from LOAD_OUT.
        run("len64_out0", 64, 0);
        check("out0_dout_count", 64'(n_dout), 64'd0);

        // Reset pulse in SQUEEZE.
        begin
            int n;
            chk_en = 1'b0;
            issue(0, 2000);
            n = 0;
            while (!dout_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("reach_squeeze", 64'(dout_valid), 64'd1);
            #2 rst = 1'b0;
            #1 check("mid_reset_idle", 64'({busy, cmd_ready, dout_valid}), 64'({1'b0, 1'b1, 1'b0}));
            @(negedge clk);
            rst = 1'b1;
            exp_q.delete();
            @(negedge clk);
            chk_en = 1'b1;
        end

        // Counter re-initialised by the next command.
        run("after_reset_len200", 200, 64);
        check("after_reset_dout_count", 64'(n_dout), 64'd1);

`ifdef SHAKE_CTRL_ABORT_EN
        // Abort during PERM_PAD: idle one cycle after perm_done.
        begin
            int n;
            chk_en = 1'b0;
            issue(0, 256);
            n = 0;
            while (!perm_start && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("abort_reach_perm", 64'(perm_start), 64'd1);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            n = 0;
            while (!perm_done && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("abort_wait_done", 64'({perm_done, busy}), 64'({1'b1, 1'b1}));
            @(negedge clk);
            check("abort_idle", 64'({busy, cmd_ready, dout_valid}), 64'({1'b0, 1'b1, 1'b0}));
            exp_q.delete();
            chk_en = 1'b1;
        end
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
